// File: rtl/spi_frame_master_pkg.sv
// spi_frame_master_pkg
//   Shared definitions for the SPI frame master: FSM state encoding and the
//   byte layout of the servo board frame, so host code and benches index the
//   frame by name instead of by magic number.
package spi_frame_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    // Servo frame, master -> slave direction
    localparam int PWM0_LO = 0;
    localparam int PWM0_HI = 1;
    localparam int PWM1_LO = 2;
    localparam int PWM1_HI = 3;
    localparam int PWM2_LO = 4;
    localparam int PWM2_HI = 5;
    localparam int PWM3_LO = 6;
    localparam int PWM3_HI = 7;
    localparam int DOUT_LO = 8;
    localparam int DOUT_HI = 9;
    localparam int DOUT_HI_ZPOL_BIT  = 7;
    localparam int DOUT_HI_QTEST_BIT = 5;

    // Servo frame, slave -> master direction (quad words are 4 bytes each)
    localparam int QUAD0 = 0;
    localparam int QUAD1 = 4;
    localparam int QUAD2 = 8;
    localparam int QUAD3 = 12;
    localparam int DIN   = 16;
    localparam int QAB   = 17;

    // Chip select is asserted in every state that belongs to a frame.
    function automatic logic ssel_active(state_t s);
        return (s == ST_SETUP) || (s == ST_LOW) || (s == ST_HIGH) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/spi_frame_master_half_tick.sv
// spi_half_tick
//   Down-counter with terminal-count strobe. Loaded with (duration - 1) on
//   entry to a timed phase; last is high on the final cycle of that phase.
//   Used for SCK half-periods and for the SETUP/HOLD/GAP intervals.
// Ports
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   load      in   load load_val this cycle
//   load_val  in   W  reload value (duration - 1)
//   last      out  count has reached zero
module spi_half_tick #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/spi_frame_master.sv
// spi_frame_master
//   SPI mode-0 master running one fixed-length chip-select frame of NBYTES
//   bytes, MSB first. Bytes to send are pulled from the host through
//   tx_idx/tx_load/tx_byte; captured bytes come back on rx_byte/rx_idx/rx_valid.
//   SCK runs continuously across byte boundaries.
// Optional build macro
//   SPI_MASTER_LOOPBACK_EN : adds input `loopback`; when high, capture samples
//                            MOSI through the MISO synchronizer instead of MISO.
// Ports
//   clk       in      system clock
//   reset     in      synchronous active-high reset
//   start     in      frame request, honoured only in IDLE
//   busy      out     frame in progress (includes the idle gap)
//   done      out     1-cycle pulse as SSEL returns high
//   tx_idx    out  6  index of the next byte to load
//   tx_load   out     tx_byte is sampled this cycle
//   tx_byte   in   8  byte to send
//   rx_byte   out  8  captured byte
//   rx_idx    out  6  index of rx_byte
//   rx_valid  out     rx_byte/rx_idx valid
//   SCK       out     SPI clock, idles low
//   MOSI      out     master out
//   MISO      in      master in, asynchronous, 2-flop synchronized
//   loopback  in      (SPI_MASTER_LOOPBACK_EN only) capture from MOSI
//   SSEL      out     active-low chip select
//
// state | meaning
// IDLE  | SSEL high, waiting for start
// SETUP | SSEL low, SCK low, CS_SETUP cycles before first rising edge
// LOW   | SCK low half-period, MOSI holds current bit
// HIGH  | SCK high half-period, MISO sampled on its last cycle
// HOLD  | SCK low, SSEL still low, CS_HOLD cycles after last falling edge
// GAP   | SSEL high for CS_IDLE cycles before the next frame may start
module spi_frame_master
    import spi_frame_master_pkg::*;
#(
    parameter int NBYTES   = 20,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [5:0] tx_idx,
    output logic       tx_load,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic [5:0] rx_idx,
    output logic       rx_valid,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic       loopback,
`endif
    output logic       SSEL
);

    localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
    localparam int MAX_CNT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);

    state_t           state;
    state_t           state_next;
    logic             last;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             tx_load_c;
    logic             more_bytes;
    logic [2:0]       bit_cnt;
    logic [6:0]       tx_sr;
    logic [6:0]       rx_sr;
    logic             cap_in;
    logic             cap_m;
    logic             cap_s;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign cap_in = loopback ? MOSI : MISO;
`else
    assign cap_in = MISO;
`endif

    // tx_idx already points past the byte in flight; with NBYTES = 64 the
    // truncated compare value is 0, which matches the wrapped index.
    assign more_bytes = (tx_idx != 6'(NBYTES));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_load_c  = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SETUP;
            ST_SETUP: if (last) begin
                          state_next = ST_LOW;
                          tx_load_c  = 1'b1;
                      end
            ST_LOW:   if (last) state_next = ST_HIGH;
            ST_HIGH:  if (last) begin
                          if (bit_cnt != 3'd7) begin
                              state_next = ST_LOW;
                          end else if (more_bytes) begin
                              state_next = ST_LOW;
                              tx_load_c  = 1'b1;
                          end else begin
                              state_next = ST_HOLD;
                          end
                      end
            ST_HOLD:  if (last) state_next = ST_GAP;
            ST_GAP:   if (last) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign tx_load  = tx_load_c;
    assign cnt_load = (state_next != state);

    always_comb begin
        cnt_load_val = '0;
        case (state_next)
            ST_SETUP:        cnt_load_val = CNT_W'(CS_SETUP - 1);
            ST_LOW, ST_HIGH: cnt_load_val = CNT_W'(CLK_DIV - 1);
            ST_HOLD:         cnt_load_val = CNT_W'(CS_HOLD - 1);
            ST_GAP:          cnt_load_val = CNT_W'(CS_IDLE - 1);
            default:         cnt_load_val = '0;
        endcase
    end

    spi_half_tick #(.W(CNT_W)) u_tick (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .last     (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_m <= 1'b0;
            cap_s <= 1'b0;
        end else begin
            cap_m <= cap_in;
            cap_s <= cap_m;
        end
    end

    // Pins and status are registered from the next state so they change on
    // the same edge as the state and never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            SCK      <= 1'b0;
            MOSI     <= 1'b0;
            SSEL     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_valid <= 1'b0;
            tx_idx   <= '0;
            rx_idx   <= '0;
            rx_byte  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
        end else begin
            SCK      <= (state_next == ST_HIGH);
            SSEL     <= !ssel_active(state_next);
            busy     <= (state_next != ST_IDLE);
            done     <= (state == ST_HOLD) && last;
            rx_valid <= 1'b0;

            if ((state == ST_IDLE) && start) begin
                tx_idx  <= '0;
                rx_idx  <= '0;
                bit_cnt <= '0;
            end

            if (tx_load_c) begin
                tx_sr   <= tx_byte[6:0];
                MOSI    <= tx_byte[7];
                tx_idx  <= tx_idx + 6'd1;
                bit_cnt <= '0;
            end

            // Capture on the last HIGH cycle to absorb the slave's SCK
            // synchronizer delay before it updates MISO.
            if ((state == ST_HIGH) && last) begin
                rx_sr <= {rx_sr[5:0], cap_s};
                if (bit_cnt != 3'd7) begin
                    tx_sr   <= {tx_sr[5:0], 1'b0};
                    MOSI    <= tx_sr[6];
                    bit_cnt <= bit_cnt + 3'd1;
                end else begin
                    rx_byte  <= {rx_sr, cap_s};
                    rx_valid <= 1'b1;
                    rx_idx   <= tx_idx - 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
module tb_spi_frame_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, tx_load, rx_valid, SCK, MOSI, SSEL;
    logic       MISO = 1'b0;
    logic [5:0] tx_idx, rx_idx;
    logic [7:0] tx_byte, rx_byte;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    always #5 clk = ~clk;

    logic [7:0] tx_mem [2];
    always_comb tx_byte = (tx_idx < 6'd2) ? tx_mem[tx_idx[0]] : 8'h00;

    spi_frame_master #(
        .NBYTES(2), .CLK_DIV(2), .CS_SETUP(4), .CS_HOLD(4), .CS_IDLE(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .tx_idx   (tx_idx),
        .tx_load  (tx_load),
        .tx_byte  (tx_byte),
        .rx_byte  (rx_byte),
        .rx_idx   (rx_idx),
        .rx_valid (rx_valid),
        .SCK      (SCK),
        .MOSI     (MOSI),
        .MISO     (MISO),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback (loopback),
`endif
        .SSEL     (SSEL)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor and MISO slave model, sampled on the falling clk edge.
    int         low_cnt = 0, nbits = 0, rx_n = 0, done_n = 0, txl_n = 0;
    int         viol = 0, frames = 0, hi_run = 0, min_gap = 1000;
    int         pos = 0, pos_d = 0, use_pos;
    logic [15:0] mosi_bits = '0;
    logic [15:0] pat = 16'h5AC3;
    logic [7:0] rx_b [64];
    logic [5:0] rx_i [64];
    logic [5:0] txl_i [64];
    logic       sck_prev = 1'b0, mosi_prev = 1'b0, ssel_prev = 1'b1;
    logic       miso_mode = 1'b0;
    logic       miso_zero = 1'b0;
    logic [3:0] bi;

    always @(negedge clk) begin
        if (!SSEL) low_cnt++;
        if (SCK && !sck_prev) begin
            mosi_bits = {mosi_bits[14:0], MOSI};
            nbits++;
        end
        if (SCK && (MOSI !== mosi_prev)) viol++;
        if (done && !SSEL) viol++;
        if (rx_valid) begin
            rx_b[rx_n[5:0]] = rx_byte;
            rx_i[rx_n[5:0]] = rx_idx;
            rx_n++;
        end
        if (done) done_n++;
        if (tx_load) begin
            txl_i[txl_n[5:0]] = tx_idx;
            txl_n++;
        end
        if (!SSEL && ssel_prev) begin
            frames++;
            if (frames > 1 && hi_run < min_gap) min_gap = hi_run;
        end
        if (SSEL) hi_run++;
        else hi_run = 0;
        // Slave: bit 7 ready at SSEL fall, next bit after each SCK fall;
        // delayed mode updates one clk cycle later.
        if (SSEL) begin
            pos   = 0;
            pos_d = 0;
        end else begin
            pos_d = pos;
            if (!SCK && sck_prev) pos++;
        end
        use_pos = miso_mode ? pos_d : pos;
        bi = 4'(15 - use_pos);
        MISO = (miso_zero || use_pos >= 16) ? 1'b0 : pat[bi];
        sck_prev  = SCK;
        mosi_prev = MOSI;
        ssel_prev = SSEL;
    end

    task automatic wait_idle(input int limit, input string tag);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_in_time"}, 32'(busy), 32'(0));
    endtask

    task automatic run_frame(input logic mode, input logic [7:0] e0, input logic [7:0] e1,
                             input string tag);
        int lc0 = low_cnt;
        int nb0 = nbits;
        int rx0 = rx_n;
        int d0  = done_n;
        int tl0 = txl_n;
        int v0  = viol;
        miso_mode = mode;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'(1));
        check({tag, "_ssel_low"}, 32'(SSEL), 32'(0));
        wait_idle(400, tag);
        check({tag, "_ssel_len"}, 32'(low_cnt - lc0), 32'(72));
        check({tag, "_nbits"}, 32'(nbits - nb0), 32'(16));
        check({tag, "_mosi"}, 32'(mosi_bits), 32'({tx_mem[0], tx_mem[1]}));
        check({tag, "_rx_cnt"}, 32'(rx_n - rx0), 32'(2));
        check({tag, "_rx0"}, 32'(rx_b[rx0[5:0]]), 32'(e0));
        check({tag, "_rx0_idx"}, 32'(rx_i[rx0[5:0]]), 32'(0));
        check({tag, "_rx1"}, 32'(rx_b[6'(rx0 + 1)]), 32'(e1));
        check({tag, "_rx1_idx"}, 32'(rx_i[6'(rx0 + 1)]), 32'(1));
        check({tag, "_done_cnt"}, 32'(done_n - d0), 32'(1));
        check({tag, "_txload_cnt"}, 32'(txl_n - tl0), 32'(2));
        check({tag, "_txload0_idx"}, 32'(txl_i[tl0[5:0]]), 32'(0));
        check({tag, "_txload1_idx"}, 32'(txl_i[6'(tl0 + 1)]), 32'(1));
        check({tag, "_pin_rules"}, 32'(viol - v0), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int f0, d0;
        tx_mem[0] = 8'hA5;
        tx_mem[1] = 8'h3C;
        repeat (3) @(negedge clk);
        check("rst_sck", 32'(SCK), 32'(0));
        check("rst_mosi", 32'(MOSI), 32'(0));
        check("rst_ssel", 32'(SSEL), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_txload", 32'(tx_load), 32'(0));
        check("rst_rxvalid", 32'(rx_valid), 32'(0));
        check("rst_txidx", 32'(tx_idx), 32'(0));
        check("rst_rxidx", 32'(rx_idx), 32'(0));
        check("rst_rxbyte", 32'(rx_byte), 32'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame, MISO updated right after SCK falls
        run_frame(1'b0, 8'h5A, 8'hC3, "f1");
        repeat (5) @(negedge clk);
        // MISO updated late after SCK falls
        run_frame(1'b1, 8'h5A, 8'hC3, "fdly");
        repeat (5) @(negedge clk);
        // Different data patterns
        tx_mem[0] = 8'h00;
        tx_mem[1] = 8'hFF;
        pat = 16'hFF00;
        run_frame(1'b1, 8'hFF, 8'h00, "f2");
        repeat (5) @(negedge clk);

        // start held high: back-to-back frames, one every 81 cycles
        f0 = frames;
        d0 = done_n;
        @(negedge clk) start = 1'b1;
        repeat (500) @(negedge clk);
        start = 1'b0;
        wait_idle(200, "flood");
        check("flood_frames", 32'(frames - f0), 32'(7));
        check("flood_done", 32'(done_n - d0), 32'(7));
        check("flood_gap_ok", 32'(min_gap >= 8), 32'(1));
        repeat (20) @(negedge clk);

        // Reset 30 cycles into a frame
        tx_mem[0] = 8'hA5;
        tx_mem[1] = 8'h3C;
        pat = 16'h5AC3;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (28) @(negedge clk);
        check("midrst_pre_ssel", 32'(SSEL), 32'(0));
        d0 = done_n;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check("midrst_ssel", 32'(SSEL), 32'(1));
        check("midrst_sck", 32'(SCK), 32'(0));
        check("midrst_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("midrst_no_done", 32'(done_n - d0), 32'(0));
        check("midrst_stays_idle", 32'(busy), 32'(0));
        run_frame(1'b0, 8'h5A, 8'hC3, "after_rst");

`ifdef SPI_MASTER_LOOPBACK_EN
        repeat (5) @(negedge clk);
        loopback  = 1'b1;
        miso_zero = 1'b1;
        tx_mem[0] = 8'h12;
        tx_mem[1] = 8'h13;
        run_frame(1'b0, 8'h12, 8'h13, "loop");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
